// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: read-only instruction memory with a prefetch queue.
// A word-addressed fetch PC issues one synchronous read per cycle into a
// one-deep read stage. The read stage feeds a circular FIFO that presents
// {instruction, pc} to decode over valid/ready. A redirect flushes the FIFO
// and the in-flight read, then restarts fetching at redirect_pc.
// Optional feature macro: INSTR_FETCH_FAULT_EN. When it is defined, each
// entry carries a fault bit for PCs at or beyond DEPTH, and out_fault is
// present. When it is not defined, out-of-range PCs alias mem[pc mod DEPTH].
module instr_fetch_queue #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 32,
    parameter int    DEPTH      = 256,
    parameter int    FIFO_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef INSTR_FETCH_FAULT_EN
    ,
    output logic                  out_fault
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Program image. There is no write port, and reset does not touch it.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Fetch PC and read stage.
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] rd_pc_q, rd_pc_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Queue storage and bookkeeping.
    logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic                  fifo_fault_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CNT_W:0]        occupancy;
    logic [IDX_W-1:0]      rd_idx;
    logic                  push_fault;
    logic [DATA_WIDTH-1:0] push_instr;

    // The low PC bits index the memory, so out-of-range PCs wrap.
    assign rd_idx = pc_q[IDX_W-1:0];

`ifdef INSTR_FETCH_FAULT_EN
    // A faulting entry carries a zero instruction so no stale word can leak.
    assign push_fault = ({1'b0, rd_pc_q} >= (ADDR_WIDTH + 1)'(DEPTH));
    assign push_instr = push_fault ? '0 : rd_data_q;
`else
    assign push_fault = 1'b0;
    assign push_instr = rd_data_q;
`endif

    // Next-state logic: redirect wins over issue, push and pop.
    always_comb begin
        pc_d       = pc_q;
        rd_valid_d = 1'b0;
        rd_pc_d    = rd_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        pop  = out_valid & out_ready & ~redirect;
        push = rd_valid_q & ~redirect;
        // The in-flight read counts as occupied, so its push never overflows.
        occupancy = {1'b0, count_q} + (CNT_W + 1)'(rd_valid_q) - (CNT_W + 1)'(pop);
        issue = ~redirect & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

        if (redirect) begin
            pc_d       = redirect_pc;
            rd_valid_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            rd_valid_d = issue;
            if (issue) begin
                pc_d    = pc_q + ADDR_WIDTH'(1);
                rd_pc_d = pc_q;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state; the asynchronous reset clears the queue at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_valid_q <= rd_valid_d;
            rd_pc_q    <= rd_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Registered memory read. It is left without a reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (issue) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    // Queue payload storage. It is written at the tail on push and needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_instr_q[tail_q] <= push_instr;
            fifo_pc_q[tail_q]    <= rd_pc_q;
            fifo_fault_q[tail_q] <= push_fault;
        end
    end

    // The head is presented while the queue is non-empty, and is zero otherwise.
    always_comb begin
        out_valid       = (count_q != '0);
        out_instruction = out_valid ? fifo_instr_q[head_q] : '0;
        out_pc          = out_valid ? fifo_pc_q[head_q] : '0;
    end

`ifdef INSTR_FETCH_FAULT_EN
    assign out_fault = out_valid ? fifo_fault_q[head_q] : 1'b0;
`endif

endmodule
